// File: rtl/pll_clken_gen.sv
// Multi-channel fractional clock-enable generator (Bresenham) gated by a filtered PLL lock.
// Optional macro PLL_CLKEN_STATS_EN adds the lol_clr / lol_count loss-of-lock statistics.
module pll_clken_gen #(
  parameter int unsigned CHANNELS  = 2,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned LOCK_FILT = 1024,
  parameter int unsigned DEF_NUM   = 1,
  parameter int unsigned DEF_DEN   = 1,
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pll_locked,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  output logic [CHANNELS-1:0] ce,
`ifdef PLL_CLKEN_STATS_EN
  input  logic                lol_clr,
  output logic [7:0]          lol_count,
`endif
  output logic                ready
);

  localparam int unsigned SUM_W  = ACC_W + 1;
  localparam int unsigned FILT_W = (LOCK_FILT > 1) ? $clog2(LOCK_FILT) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILT - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    RUN
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic                lk;
  logic [FILT_W-1:0]   cnt_q, cnt_d;
  logic                upd_c;

  logic [ACC_W-1:0]    num_q     [CHANNELS];
  logic [ACC_W-1:0]    den_q     [CHANNELS];
  logic [ACC_W-1:0]    acc_q     [CHANNELS];
  logic [ACC_W-1:0]    num_eff_c [CHANNELS];
  logic [SUM_W-1:0]    sum_c     [CHANNELS];
  logic [CHANNELS-1:0] wr_c;

  // Two-flop synchroniser for the asynchronous lock flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], pll_locked};
  end

  assign lk = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_LOCK;
      cnt_q   <= '0;
      ready   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready   <= (state_d == RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    upd_c   = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (lk) state_d = FILTER;
      end
      FILTER: begin
        if (!lk) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == FILT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + FILT_W'(1);
        end
      end
      RUN: begin
        cnt_d = '0;
        upd_c = lk;
        if (!lk) state_d = WAIT_LOCK;
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Clamp num to den so over-unity rates saturate at one strobe per cycle
  always_comb begin
    for (int i = 0; i < int'(CHANNELS); i++) begin
      num_eff_c[i] = (num_q[i] > den_q[i]) ? den_q[i] : num_q[i];
      sum_c[i]     = SUM_W'(acc_q[i]) + SUM_W'(num_eff_c[i]);
      wr_c[i]      = cfg_we && (32'(cfg_ch) == 32'(i));
    end
  end

  // A config write beats the accumulator update and restarts that channel's phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        num_q[i] <= ACC_W'(DEF_NUM);
        den_q[i] <= ACC_W'(DEF_DEN);
        acc_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (wr_c[i]) begin
          num_q[i] <= cfg_num;
          den_q[i] <= cfg_den;
          acc_q[i] <= '0;
          ce[i]    <= 1'b0;
        end else if (upd_c && (den_q[i] != '0)) begin
          if (sum_c[i] >= SUM_W'(den_q[i])) begin
            acc_q[i] <= ACC_W'(sum_c[i] - SUM_W'(den_q[i]));
            ce[i]    <= 1'b1;
          end else begin
            acc_q[i] <= ACC_W'(sum_c[i]);
            ce[i]    <= 1'b0;
          end
        end else begin
          acc_q[i] <= '0;
          ce[i]    <= 1'b0;
        end
      end
    end
  end

`ifdef PLL_CLKEN_STATS_EN
  // Saturating count of RUN -> WAIT_LOCK transitions; clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          lol_count <= 8'd0;
    else if (lol_clr)                                    lol_count <= 8'd0;
    else if ((state_q == RUN) && !lk && (lol_count != 8'hFF)) lol_count <= lol_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pll_clken_gen.sv
// Directed scoreboard bench for pll_clken_gen (3 channels, LOCK_FILT=8).
// Exercises lock filtering, fractional rates, config-write priority and optional stats.
module tb_pll_clken_gen;

  localparam int unsigned CH = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned LF = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pll_locked;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [AW-1:0] cfg_num;
  logic [AW-1:0] cfg_den;
  logic [CH-1:0] ce;
  logic          ready;
`ifdef PLL_CLKEN_STATS_EN
  logic          lol_clr;
  logic [7:0]    lol_count;
`endif

  typedef struct {
    logic [CH-1:0] ce;
    logic [CH-1:0] mask;
    logic          ready;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  pll_clken_gen #(
    .CHANNELS (CH),
    .ACC_W    (AW),
    .LOCK_FILT(LF),
    .DEF_NUM  (1),
    .DEF_DEN  (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .ce        (ce),
`ifdef PLL_CLKEN_STATS_EN
    .lol_clr   (lol_clr),
    .lol_count (lol_count),
`endif
    .ready     (ready)
  );

  function automatic logic rate_1_4(input int k);
    return (k > 0) && ((k % 4) == 0);
  endfunction

  // 3/8 Bresenham pattern: strobes at phase 3, 6 and 8 of every 8
  function automatic logic rate_3_8(input int k);
    return (k > 0) && (((k % 8) == 3) || ((k % 8) == 6) || ((k % 8) == 0));
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [CH-1:0] e_ce, input logic [CH-1:0] mask,
                      input logic e_rdy);
    exp_t e;
    sb.push_back('{e_ce, mask, e_rdy});
    tick();
    e = sb.pop_front();
    chk({tag, "/ce"}, 32'(ce & e.mask), 32'(e.ce & e.mask));
    chk({tag, "/ready"}, 32'(ready), 32'(e.ready));
  endtask

  task automatic wr_step(input string tag, input logic [1:0] ch, input logic [AW-1:0] num,
                         input logic [AW-1:0] den, input logic [CH-1:0] e_ce,
                         input logic [CH-1:0] mask, input logic e_rdy);
    cfg_we  = 1'b1;
    cfg_ch  = ch;
    cfg_num = num;
    cfg_den = den;
    step(tag, e_ce, mask, e_rdy);
    cfg_we  = 1'b0;
  endtask

  task automatic wait_ready(input string tag, input int max_cyc, output int n);
    n = 0;
    while (!ready && (n < max_cyc)) begin
      tick();
      n++;
    end
    chk(tag, 32'(ready), 32'(1));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pulses;
    logic [CH-1:0] e;

    rst_n      = 1'b0;
    pll_locked = 1'b1;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_num    = '0;
    cfg_den    = '0;
`ifdef PLL_CLKEN_STATS_EN
    lol_clr    = 1'b0;
`endif
    tick();
    tick();
    chk("reset_ce", 32'(ce), 32'(0));
    chk("reset_ready", 32'(ready), 32'(0));
`ifdef PLL_CLKEN_STATS_EN
    chk("reset_lol", 32'(lol_count), 32'(0));
`endif

    // Lock from t0: 2 sync + WAIT_LOCK entry + 8 filter cycles
    rst_n = 1'b1;
    wait_ready("lock_ready", 40, n);
    chk("lock_latency_ok", 32'((n >= 10) && (n <= 12)), 32'(1));
    chk("first_run_ce", 32'(ce), 32'(0));
    for (int k = 0; k < 3; k++) step("default_1_1", 3'b111, 3'b111, 1'b1);

    // ch0 = 1/4, ch1 = 3/8
    wr_step("wr_ch0", 2'd0, 8'd1, 8'd4, 3'b110, 3'b111, 1'b1);
    wr_step("wr_ch1", 2'd1, 8'd3, 8'd8, 3'b100, 3'b111, 1'b1);
    pulses = 0;
    for (int k = 3; k <= 18; k++) begin
      e = {1'b1, rate_3_8(k - 2), rate_1_4(k - 1)};
      step("rates", e, 3'b111, 1'b1);
      if (ce[1]) pulses++;
    end
    chk("ch1_3_per_8", 32'(pulses), 32'(6));

    // Loss of lock in RUN
    pll_locked = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (ready && (n < 3));
    chk("lol_ready", 32'(ready), 32'(0));
    chk("lol_ce", 32'(ce), 32'(0));
    for (int k = 0; k < 3; k++) step("unlocked", 3'b000, 3'b111, 1'b0);

    // Relock with a one-cycle glitch seen while the filter count is 5
    for (int k = 1; k <= 18; k++) begin
      pll_locked = (k != 7);
      step("refilter", 3'b000, 3'b111, k == 18);
    end

    // Phases restart from zero with retained num/den
    for (int k = 1; k <= 8; k++) begin
      e = {1'b1, rate_3_8(k), rate_1_4(k)};
      step("restart", e, 3'b111, 1'b1);
    end

    // den=0, out-of-range channel, and write colliding with a due strobe
    wr_step("wr_ch0_again", 2'd0, 8'd1, 8'd4, 3'b000, 3'b001, 1'b1);
    for (int k = 1; k <= 13; k++) begin
      e = {1'b1, 1'b0, (k == 8) || (k == 12)};
      if (k == 1)      wr_step("den0", 2'd1, 8'd3, 8'd0, e, 3'b111, 1'b1);
      else if (k == 2) wr_step("bad_ch", 2'd3, 8'd0, 8'd0, e, 3'b111, 1'b1);
      else if (k == 4) wr_step("collide", 2'd0, 8'd1, 8'd4, e, 3'b111, 1'b1);
      else             step("boundary", e, 3'b111, 1'b1);
    end

    // num > den clamps to every cycle
    wr_step("wr_5_3", 2'd1, 8'd5, 8'd3, 3'b000, 3'b010, 1'b1);
    for (int k = 0; k < 6; k++) step("clamp", 3'b010, 3'b010, 1'b1);

    // num=0 never strobes
    wr_step("wr_0_4", 2'd2, 8'd0, 8'd4, 3'b000, 3'b100, 1'b1);
    for (int k = 0; k < 6; k++) step("num0", 3'b000, 3'b100, 1'b1);

`ifdef PLL_CLKEN_STATS_EN
    lol_clr = 1'b1;
    tick();
    lol_clr = 1'b0;
    chk("lol_cleared", 32'(lol_count), 32'(0));
    for (int i = 1; i <= 3; i++) begin
      pll_locked = 1'b1;
      wait_ready("stats_relock", 40, n);
      pll_locked = 1'b0;
      tick();
      tick();
      tick();
      chk("stats_ready", 32'(ready), 32'(0));
      chk("stats_count", 32'(lol_count), 32'(i));
    end
    pll_locked = 1'b1;
    wait_ready("stats_relock4", 40, n);
    pll_locked = 1'b0;
    tick();
    tick();
    chk("stats_pre_clr", 32'(lol_count), 32'(3));
    lol_clr = 1'b1;
    tick();
    lol_clr = 1'b0;
    chk("stats_clr_wins", 32'(lol_count), 32'(0));
    chk("stats_ready4", 32'(ready), 32'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pll_clken_gen.md
Name: pll_clken_gen

Overview:
Parametrised multi-channel clock-enable generator behind the PLL wrapper. Runs on one PLL output clock and derives CHANNELS fractional-rate clock-enable strobes using Bresenham accumulators (rate = num/den of clk). Each channel's num/den is runtime-programmable. Strobes are gated by a filtered, synchronised PLL lock, with automatic restart after loss of lock.

Parameters:
CHANNELS, 2, number of enable channels (1..16)
ACC_W, 16, width of num, den and accumulators
LOCK_FILT, 1024, consecutive synchronised-locked cycles required before RUN (>=1)
DEF_NUM, 1, reset value of num for every channel
DEF_DEN, 1, reset value of den for every channel

Ports:
clk  in  1  PLL output clock; all logic is on this clock
rst_n  in  1  asynchronous, active-low reset
pll_locked  in  1  PLL lock flag, asynchronous to clk
cfg_we  in  1  single-cycle config write strobe
cfg_ch  in  max(1,$clog2(CHANNELS))  channel index for the write
cfg_num  in  ACC_W  numerator for the write
cfg_den  in  ACC_W  denominator for the write
ce  out  CHANNELS  registered one-cycle enable strobes, one bit per channel
ready  out  1  high while the state machine is in RUN

Behaviour:
- Reset: ce=0, ready=0, state=WAIT_LOCK, filter counter=0, all accumulators=0, num=DEF_NUM, den=DEF_DEN.
- pll_locked passes through a 2-FF synchroniser; lk denotes the synchronised value.
- WAIT_LOCK: filter counter=0. When lk=1, go to FILTER.
- FILTER: counter increments while lk=1. If lk=0, go to WAIT_LOCK and clear counter. When counter reaches LOCK_FILT-1 with lk=1, go to RUN.
- RUN: ready=1 (registered, high from first RUN cycle). If lk=0, go to WAIT_LOCK. ready and ce are 0 from the next cycle. All accumulators clear. num/den are retained.
- Accumulator update, per channel, only in RUN:
  - s = acc + num, computed at ACC_W+1 bits.
  - If den=0: channel disabled, ce=0, acc held at 0.
  - Else if s >= den: acc <= s - den, ce <= 1 on the next cycle.
  - Else: acc <= s, ce <= 0.
- num > den is clamped to den, giving ce every cycle. num=0 gives ce never.
- Latency: the update in cycle t drives ce in cycle t+1. With num=1, den=4, the first ce is 4 cycles after ready rises, then every 4 cycles.
- Config write:
  - Accepted in any state. cfg_ch >= CHANNELS is ignored.
  - The new num/den take effect the next cycle, and that channel's acc clears to 0.
  - If a write collides with that channel's RUN update in the same cycle, the write wins and the resulting ce is 0.
  - Other channels are unaffected.
- Long-run ce rate is exact: over den cycles, exactly num strobes (no drift).

Optional Feature:
PLL_CLKEN_STATS_EN:
- Defined: adds output lol_count (8 bits), reset 0, which increments (saturating at 255) on each RUN->WAIT_LOCK transition. Adds input lol_clr (1 bit), which synchronously clears lol_count. If lol_clr and an increment occur in the same cycle, clear wins.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
1. Reset with defaults, pll_locked=1 from t0, LOCK_FILT=8 -> ready rises 2 sync + 8 filter cycles later. Then ce=all-ones every cycle (1/1).
2. Write ch0 num=1 den=4 and ch1 num=3 den=8 in RUN -> ch0 pulses every 4th cycle, first at +4 after the write takes effect. ch1 gives exactly 3 pulses per 8 cycles (pattern at +3,+6,+8), repeating.
3. pll_locked drops for 1 cycle during FILTER at count 5 -> back to WAIT_LOCK, counter restarts. ready rises only after 8 further consecutive locked cycles.
4. Lock lost in RUN -> ready=0 and ce=0 within 3 cycles (sync + 1). On relock, ch0 (1/4) restarts with first ce 4 cycles after ready; num/den retained.
5. Boundaries:
   - den=0 -> ce never.
   - num=5 den=3 -> ce every cycle.
   - cfg_ch=CHANNELS -> no channel changes.
   - Write to ch0 in the cycle its ce would fire -> that ce suppressed, acc restarts from 0.
6. With PLL_CLKEN_STATS_EN: 3 lock losses -> lol_count=3. lol_clr together with a 4th loss -> lol_count=0.
